// File: rtl/ucie_sb_tx_scheduler_pkg.sv
// Shared sideband transmit definitions: beat width, default idle gap and the
// scheduler state encoding.
package ucie_sb_pkg;

    localparam int SB_BEAT_W         = 64;
    localparam int SB_DEFAULT_GAP_UI = 32;
    localparam int SB_BEAT_CYCLES    = 2 * SB_BEAT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        GAP  = 2'd2,
        DATA = 2'd3
    } sb_tx_state_e;

    // Round-robin successor of a granted index.
    function automatic int rr_next(input int idx, input int num);
        return (idx == num - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ucie_sb_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the
// pointer, wrapping around. The pointer register lives with the caller.
module ucie_sb_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (enable && !grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ucie_sb_tx_scheduler.sv
// Sideband transmit scheduler: round-robin grant of one requester, then LSB-first
// serialization of header and optional data beat, each followed by an idle gap.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no message; grant issued here when tx_enable and a request exist
//   HDR   | shifting out the 64-bit header, 2 cycles per UI
//   GAP   | GAP_UI idle UIs after a beat; clock and data held low
//   DATA  | shifting out the held 64-bit data beat
module ucie_sb_tx_scheduler
    import ucie_sb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int GAP_UI  = SB_DEFAULT_GAP_UI,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tx_enable,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_has_data,
    input  logic [NUM_REQ*SB_BEAT_W-1:0] req_hdr,
    input  logic [NUM_REQ*SB_BEAT_W-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         SBTX_CLK,
    output logic                         SBTX_DATA,
    output logic                         busy,
    output logic [IDX_W-1:0]             grant_id
);

    localparam int               GAP_CYC  = 2 * GAP_UI;
    localparam int               GAP_W    = $clog2(GAP_CYC);
    localparam logic [6:0]       BIT_LAST = 7'(SB_BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    sb_tx_state_e         state_q, state_d;
    logic [SB_BEAT_W-1:0] shift_q, shift_d;
    logic [SB_BEAT_W-1:0] hold_q, hold_d;
    logic                 has_data_q, has_data_d;
    logic [6:0]           bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     grant_id_q, grant_id_d;
    logic                 sbtx_clk_q, sbtx_clk_d;
    logic                 sbtx_data_q, sbtx_data_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic                 arb_en;
    logic                 in_beat;
    logic                 beat_done;
    logic                 gap_done;

    assign arb_en    = tx_enable && (state_q == IDLE);
    assign in_beat   = (state_q == HDR) || (state_q == DATA);
    assign beat_done = (bit_cnt_q == BIT_LAST);
    assign gap_done  = (gap_cnt_q == GAP_LAST);

    ucie_sb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr_q),
        .enable      (arb_en),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            has_data_q  <= 1'b0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            ptr_q       <= '0;
            grant_id_q  <= '0;
            sbtx_clk_q  <= 1'b0;
            sbtx_data_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            has_data_q  <= has_data_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            sbtx_clk_q  <= sbtx_clk_d;
            sbtx_data_q <= sbtx_data_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = HDR;
                end
            end
            HDR, DATA: begin
                if (beat_done) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_d = has_data_q ? DATA : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d    = shift_q;
        hold_d     = hold_q;
        has_data_d = has_data_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        if (state_q == IDLE && arb_valid) begin
            shift_d    = req_hdr[arb_idx*SB_BEAT_W +: SB_BEAT_W];
            hold_d     = req_data[arb_idx*SB_BEAT_W +: SB_BEAT_W];
            has_data_d = req_has_data[arb_idx];
            grant_id_d = arb_idx;
            ptr_d      = IDX_W'(rr_next(int'(arb_idx), NUM_REQ));
        end

        if (in_beat) begin
            bit_cnt_d = bit_cnt_q + 7'd1;
            // Advance to the next bit at the end of each UI (after the high phase).
            if (bit_cnt_q[0]) begin
                shift_d = shift_q >> 1;
            end
        end

        if (state_q == GAP) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
            if (gap_done && has_data_q) begin
                shift_d    = hold_q;
                has_data_d = 1'b0;
            end
        end

        if (state_d != state_q) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
        end
    end

    // Output flops are loaded from next-state values so the pins line up with
    // the state they describe; the first header bit appears right after ready.
    always_comb begin
        busy_d      = (state_d != IDLE);
        sbtx_clk_d  = 1'b0;
        sbtx_data_d = 1'b0;
        if (state_d == HDR || state_d == DATA) begin
            sbtx_clk_d  = bit_cnt_d[0];
            sbtx_data_d = shift_d[0];
        end
    end

    assign req_ready = arb_grant;
    assign SBTX_CLK  = sbtx_clk_q;
    assign SBTX_DATA = sbtx_data_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_ucie_sb_tx_scheduler.sv
// Scoreboard bench for the sideband transmit scheduler: a message-level model
// predicts grants and pin activity; a serial receiver checks captured words.
module tb_ucie_sb_tx_scheduler;

    localparam int NR    = 4;
    localparam int G     = 32;
    localparam int BEAT  = 128;
    localparam int GAPC  = 2 * G;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            tx_enable = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_has_data = '0;
    logic [NR*64-1:0] req_hdr = '0;
    logic [NR*64-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            SBTX_CLK;
    logic            SBTX_DATA;
    logic            busy;
    logic [1:0]      grant_id;

    ucie_sb_tx_scheduler #(.NUM_REQ(NR), .GAP_UI(G)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_enable    (tx_enable),
        .req_valid    (req_valid),
        .req_has_data (req_has_data),
        .req_hdr      (req_hdr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .SBTX_CLK     (SBTX_CLK),
        .SBTX_DATA    (SBTX_DATA),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] sb_q[$];
    int          mon_nb = 0;

    // Requester-side state and message-level model
    logic [NR-1:0] pend_v = '0;
    logic [NR-1:0] pend_hd = '0;
    logic [63:0]   pend_h[NR];
    logic [63:0]   pend_d[NR];
    bit            tx_en_r = 0;
    bit            rearm = 0;
    int            cyc = 0;
    int            avail = 0;
    int            ms = 0;
    int            me = 0;
    int            mptr = 0;
    int            last_win = 0;
    logic [63:0]   cur_h = '0;
    logic [63:0]   cur_d = '0;
    bit            cur_hd = 0;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic [NR-1:0] er;
        bit eb, ec, ed;
        int off, win;
        @(negedge clk);
        tx_enable    = tx_en_r;
        req_valid    = pend_v;
        req_has_data = pend_hd;
        for (int i = 0; i < NR; i++) begin
            req_hdr[64*i +: 64]  = pend_h[i];
            req_data[64*i +: 64] = pend_d[i];
        end
        #1;
        eb = (cyc >= ms) && (cyc < me);
        ec = 0;
        ed = 0;
        if (eb) begin
            off = cyc - ms;
            if (off < BEAT) begin
                ec = (off % 2) == 1;
                ed = cur_h[off/2];
            end else if (cur_hd && off >= BEAT + GAPC && off < 2*BEAT + GAPC) begin
                off = off - (BEAT + GAPC);
                ec = (off % 2) == 1;
                ed = cur_d[off/2];
            end
        end
        chk("busy", busy, eb);
        chk("sbtx_clk", SBTX_CLK, ec);
        chk("sbtx_data", SBTX_DATA, ed);
        chk("grant_id", grant_id, last_win);
        er  = '0;
        win = -1;
        if (cyc >= avail && tx_en_r && pend_v != '0) begin
            for (int k = 0; k < NR; k++) begin
                if (win < 0 && pend_v[(mptr + k) % NR]) win = (mptr + k) % NR;
            end
        end
        if (win >= 0) begin
            er[win] = 1'b1;
            ms      = cyc + 1;
            cur_h   = pend_h[win];
            cur_d   = pend_d[win];
            cur_hd  = pend_hd[win];
            me      = ms + BEAT + GAPC + (cur_hd ? BEAT + GAPC : 0);
            avail   = me;
            sb_q.push_back(cur_h);
            if (cur_hd) sb_q.push_back(cur_d);
            mptr     = (win + 1) % NR;
            last_win = win;
            if (rearm) begin
                pend_h[win] = rand64();
                pend_d[win] = rand64();
            end else begin
                pend_v[win] = 1'b0;
            end
        end
        chk("req_ready", req_ready, er);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        tx_en_r   = 0;
        pend_v    = '0;
        tx_enable = 1'b0;
        req_valid = '0;
        cyc++;
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_sbtx_clk", SBTX_CLK, 0);
        chk("rst_sbtx_data", SBTX_DATA, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_ready", req_ready, 0);
        reset = 1'b0;
        sb_q.delete();
        mptr     = 0;
        last_win = 0;
        ms       = 0;
        me       = 0;
        avail    = 0;
        cyc++;
    endtask

    task automatic arm(input int i, input logic [63:0] h, input logic [63:0] d, input bit hd);
        pend_h[i]  = h;
        pend_d[i]  = d;
        pend_hd[i] = hd;
        pend_v[i]  = 1'b1;
    endtask

    // Serial receiver: capture SBTX_DATA on each SBTX_CLK rising edge.
    initial begin
        logic        prev;
        logic [63:0] acc;
        logic [63:0] e;
        prev = 1'b0;
        acc  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                mon_nb = 0;
                prev   = 1'b0;
            end else begin
                if (SBTX_CLK === 1'b1 && prev === 1'b0) begin
                    acc[mon_nb] = SBTX_DATA;
                    mon_nb++;
                    if (mon_nb == 64) begin
                        mon_nb = 0;
                        if (sb_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL sb_word: got %h with no word expected", acc);
                        end else begin
                            e = sb_q.pop_front();
                            chk("sb_word", acc, e);
                        end
                    end
                end
                prev = SBTX_CLK;
            end
        end
    end

    initial begin
        int target;
        for (int i = 0; i < NR; i++) begin
            pend_h[i] = '0;
            pend_d[i] = '0;
        end
        do_reset();

        // tx_enable low with every requester valid: nothing may start
        for (int i = 0; i < NR; i++) arm(i, rand64(), rand64(), 1'b0);
        run(300);
        pend_v = '0;
        run(2);

        // Single header-only message
        tx_en_r = 1;
        arm(0, 64'h0000_0000_0000_0001, 64'h0, 1'b0);
        run(200);

        // Header plus data from requester 2
        arm(2, 64'hA5A5_A5A5_A5A5_A5A5, 64'hFFFF_0000_FFFF_0000, 1'b1);
        run(400);

        // Round-robin with all requesters continuously valid
        do_reset();
        for (int i = 0; i < NR; i++) arm(i, rand64(), rand64(), 1'b0);
        rearm   = 1;
        tx_en_r = 1;
        run(5 * 193);
        rearm  = 0;
        pend_v = '0;
        run(200);

        // tx_enable drop during header bit 10
        arm(1, rand64(), rand64(), 1'b0);
        arm(3, rand64(), rand64(), 1'b0);
        tx_en_r = 1;
        run(1);
        run(21);
        tx_en_r = 0;
        run(300);
        tx_en_r = 1;
        run(250);

        // Reset at data bit 20
        arm(1, rand64(), rand64(), 1'b1);
        run(1);
        target = ms + BEAT + GAPC + 40;
        for (int n = 0; n < 1000 && cyc < target; n++) step();
        do_reset();
        arm(0, rand64(), rand64(), 1'b0);
        arm(2, rand64(), rand64(), 1'b0);
        tx_en_r = 1;
        run(451);

        // Wrap-around: serve 2, then 3 before 1
        do_reset();
        tx_en_r = 1;
        arm(2, rand64(), rand64(), 1'b0);
        run(1);
        arm(1, rand64(), rand64(), 1'b0);
        arm(3, rand64(), rand64(), 1'b0);
        run(450);

        // Randomized traffic with withdrawals and enable toggling
        tx_en_r = 1;
        for (int n = 0; n < 12000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend_v[i] && $urandom_range(0, 59) == 0)
                    arm(i, rand64(), rand64(), 1'($urandom_range(0, 1)));
                else if (pend_v[i] && $urandom_range(0, 399) == 0)
                    pend_v[i] = 1'b0;
            end
            if ($urandom_range(0, 499) == 0) tx_en_r = !tx_en_r;
            step();
        end

        tx_en_r = 0;
        pend_v  = '0;
        run(500);
        chk("sb_queue_empty", 64'(sb_q.size()), 0);
        chk("mon_partial_bits", 64'(mon_nb), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
